btb_assoc: RTL

//  Parametrised set-associative branch target buffer for the fetch stage. Each cycle, up to

---
 rtl/btb_assoc_pkg.sv | 23 ++
 rtl/btb_lru_set.sv | 27 ++
 rtl/btb_assoc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/btb_assoc_pkg.sv
// btb_assoc_pkg: shared constants, BTB entry layout and counter helper for the branch target buffer
//   XLEN       architectural PC width
//   BTB_WIDTH  default number of fetch/retire lanes
//   TAG_BITS   stored tag width (owned here because it fixes the entry layout)
//   TGT_BITS   stored word-aligned target width (owned here for the same reason)
//   btb_entry_t  valid, tag, 2-bit direction counter, target offset
package btb_assoc_pkg;
  localparam int XLEN = 32;
  localparam int BTB_WIDTH = 2;
  localparam int TAG_BITS = 10;
  localparam int TGT_BITS = 12;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;
  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          ctr;
    logic [TGT_BITS-1:0] target;
  } btb_entry_t;
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    return up ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/btb_lru_set.sv
// btb_lru_set: age-based LRU state of one set, applying an ordered list of touches
//   i_age    current age per way (0 = most recent, WAYS-1 = replacement victim)
//   i_touch  enable per list slot; slot 0 is applied first
//   i_way    way touched by each slot
//   o_age    ages after every enabled touch, still a permutation of 0..WAYS-1
module btb_lru_set #(
  parameter int WAYS = 4,
  parameter int NT = 2,
  localparam int AB = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AB-1:0] i_age,
  input  logic [NT-1:0]           i_touch,
  input  logic [NT-1:0][AB-1:0]   i_way,
  output logic [WAYS-1:0][AB-1:0] o_age
);
  logic [AB-1:0] w_old;
  always_comb begin
    o_age = i_age;
    w_old = '0;
    for (int t = 0; t < NT; t++)
      if (i_touch[t]) begin
        w_old = o_age[i_way[t]];
        for (int w = 0; w < WAYS; w++)
          o_age[w] = (AB'(w) == i_way[t]) ? '0 : (o_age[w] < w_old) ? o_age[w] + AB'(1) : o_age[w];
      end
  end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit counters and LRU replacement
//   i_clock/i_reset   rising-edge clock, synchronous active-high reset
//   i_flush_all       invalidate every entry at the next edge (beats same-cycle updates)
//   i_lookup_*        WIDTH fetch lanes; o_pred_* answered combinationally from registered state
//   i_upd_*           WIDTH retire lanes, applied lane 0 first, visible one cycle later
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int WIDTH = BTB_WIDTH,
  parameter int SETS = 64,
  parameter int WAYS = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush_all,
  input  logic [WIDTH-1:0]           i_lookup_valid,
  input  logic [WIDTH-1:0][XLEN-1:0] i_lookup_pc,
  output logic [WIDTH-1:0]           o_pred_hit,
  output logic [WIDTH-1:0]           o_pred_taken,
  output logic [WIDTH-1:0][XLEN-1:0] o_pred_tpc,
  input  logic [WIDTH-1:0]           i_upd_valid,
  input  logic [WIDTH-1:0][XLEN-1:0] i_upd_pc,
  input  logic [WIDTH-1:0]           i_upd_taken,
  input  logic [WIDTH-1:0]           i_upd_uncond,
  input  logic [WIDTH-1:0][XLEN-1:0] i_upd_target
);
  localparam int IB = $clog2(SETS);
  localparam int AB = $clog2(WAYS);
  btb_entry_t r_entry [SETS][WAYS];
  btb_entry_t w_entry_n [SETS][WAYS];
  logic [WAYS-1:0][AB-1:0] r_age [SETS];
  logic [WAYS-1:0][AB-1:0] w_age_look [SETS];
  logic [WAYS-1:0][AB-1:0] w_age_n [SETS];
  logic [WIDTH-1:0][IB-1:0] w_lk_idx;
  logic [WIDTH-1:0][AB-1:0] w_lk_way;
  logic [IB-1:0] w_u_idx;
  logic [TAG_BITS-1:0] w_u_tag;
  logic [AB-1:0] w_u_way;
  logic w_u_hit;
  logic w_u_alloc;
  logic w_unused;
  assign w_unused = ^{i_upd_pc, i_upd_target};
  function automatic logic [WAYS-1:0][AB-1:0] touch(input logic [WAYS-1:0][AB-1:0] a, input logic [AB-1:0] way);
    logic [WAYS-1:0][AB-1:0] r;
    for (int w = 0; w < WAYS; w++)
      r[w] = (AB'(w) == way) ? '0 : (a[w] < a[way]) ? a[w] + AB'(1) : a[w];
    return r;
  endfunction
  // Lookups see only registered state; the lowest matching way wins (duplicates cannot arise).
  always_comb begin
    w_lk_idx = '0;
    w_lk_way = '0;
    o_pred_hit = '0;
    o_pred_taken = '0;
    o_pred_tpc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_lk_idx[i] = i_lookup_pc[i][IB+1:2];
      for (int w = WAYS - 1; w >= 0; w--)
        if (i_lookup_valid[i] && r_entry[w_lk_idx[i]][w].valid &&
            r_entry[w_lk_idx[i]][w].tag == i_lookup_pc[i][IB+TAG_BITS+1:IB+2]) begin
          o_pred_hit[i] = 1'b1;
          w_lk_way[i] = AB'(w);
        end
      o_pred_taken[i] = o_pred_hit[i] && r_entry[w_lk_idx[i]][w_lk_way[i]].ctr[1];
      o_pred_tpc[i] = !i_lookup_valid[i] ? '0 :
                      o_pred_hit[i] ? {i_lookup_pc[i][XLEN-1:TGT_BITS+2], r_entry[w_lk_idx[i]][w_lk_way[i]].target, 2'b00} :
                      i_lookup_pc[i] + XLEN'(4);
    end
  end
  // Lookup-hit touches are applied per set before any retire-lane touch.
  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic [WIDTH-1:0] w_touch;
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign w_touch[i] = o_pred_hit[i] && (w_lk_idx[i] == IB'(s));
    end
    btb_lru_set #(.WAYS(WAYS), .NT(WIDTH)) u_lru (
      .i_age   (r_age[s]),
      .i_touch (w_touch),
      .i_way   (w_lk_way),
      .o_age   (w_age_look[s])
    );
  end
  // Retire lanes run in order on a working copy so each lane sees lower lanes' allocations and touches.
  always_comb begin
    w_entry_n = r_entry;
    w_age_n = w_age_look;
    w_u_idx = '0;
    w_u_tag = '0;
    w_u_way = '0;
    w_u_hit = 1'b0;
    w_u_alloc = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      w_u_idx = i_upd_pc[k][IB+1:2];
      w_u_tag = i_upd_pc[k][IB+TAG_BITS+1:IB+2];
      w_u_hit = 1'b0;
      w_u_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (w_entry_n[w_u_idx][w].valid && w_entry_n[w_u_idx][w].tag == w_u_tag) begin
          w_u_hit = 1'b1;
          w_u_way = AB'(w);
        end
      if (!w_u_hit) begin
        for (int w = 0; w < WAYS; w++)
          if (w_age_n[w_u_idx][w] == AB'(WAYS - 1)) w_u_way = AB'(w);
        for (int w = WAYS - 1; w >= 0; w--)
          if (!w_entry_n[w_u_idx][w].valid) w_u_way = AB'(w);
      end
      w_u_alloc = i_upd_valid[k] && !w_u_hit && (i_upd_taken[k] || i_upd_uncond[k]);
      if (i_upd_valid[k] && w_u_hit) begin
        w_entry_n[w_u_idx][w_u_way].ctr = i_upd_uncond[k] ? CTR_STRONG_T : ctr_step(w_entry_n[w_u_idx][w_u_way].ctr, i_upd_taken[k]);
        if (i_upd_uncond[k] || i_upd_taken[k]) w_entry_n[w_u_idx][w_u_way].target = i_upd_target[k][TGT_BITS+1:2];
      end
      if (w_u_alloc)
        w_entry_n[w_u_idx][w_u_way] = '{valid: 1'b1, tag: w_u_tag, ctr: i_upd_uncond[k] ? CTR_STRONG_T : CTR_WEAK_T, target: i_upd_target[k][TGT_BITS+1:2]};
      if ((i_upd_valid[k] && w_u_hit) || w_u_alloc) w_age_n[w_u_idx] = touch(w_age_n[w_u_idx], w_u_way);
    end
    if (i_flush_all)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          w_entry_n[s][w] = r_entry[s][w];
          w_entry_n[s][w].valid = 1'b0;
          w_age_n[s][w] = AB'(w);
        end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          r_entry[s][w] <= '0;
          r_age[s][w] <= AB'(w);
        end
    end else begin
      r_entry <= w_entry_n;
      r_age <= w_age_n;
    end
  end
endmodule
